fpu_sequencer: RTL
==================

Name: fpu_sequencer

Overview:
- Multi-cycle control FSM for the floating point datapath.
- Accepts one command at a time over a valid/ready handshake.
- Steps the datapath through unpack -> align -> execute -> normalize -> pack by driving a stage code and enables.
- Holds the result-valid flag until the consumer takes it.
- Sits between the instruction issue logic and the FPU datapath; owns all timing, the datapath stays combinational per stage.

Parameters:
- bitness, 64, FP word width minus one (same convention as the datapath: 16/32/64/128/256 formats).
- mul_cycles, 4, cycles spent in the mul stage (minimum 1).

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd  in  2  operation: 00 add, 01 sub, 10 mul, 11 div.
- dp_special  in  1  datapath flag, sampled in unpack: operand is NaN/inf/zero, result is known.
- dp_norm_done  in  1  datapath flag: mantissa is normalized.
- stage  out  4  current stage code driven to the datapath.
- stage_en  out  1  datapath registers update this cycle.
- op  out  2  latched command.
- res_valid  out  1  packed result available.
- res_ready  in  1  consumer takes the result.
- busy  out  1  not idle.

Behaviour:
- Stage codes: unpack 0000, pack 0001, align 0010, normalize 0011, sum 0100, sub 0101, mul 0110, div 1000, result 1110, idle 1111.
- Reset (asynchronous, any time including mid-operation) forces the following, with no pending result kept:
  - state idle, stage 1111, op 00, stage_en 0, res_valid 0, busy 0, internal counters 0.
  - cmd_ready 1 once out of reset.
- idle:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: latch cmd into op; next state unpack.
- unpack, 1 cycle:
  - If dp_special=1, go to pack.
  - Else add/sub go to align; mul go to mul; div go to div.
- align, 1 cycle: go to sum (op 00) or sub (op 01).
- sum/sub, 1 cycle each: go to normalize.
- mul: stays mul_cycles cycles (counter from 0 to mul_cycles-1), then normalize.
- div: stays div_cycles = MANT_BITS+2 cycles, then normalize.
  - MANT_BITS = 11/24/53/113/237 for bitness 16/32/64/128/256.
  - bitness 64 gives 55 cycles.
- normalize:
  - Each cycle, if dp_norm_done=1 go to pack.
  - Else stay, incrementing the norm counter.
  - Forced exit to pack after MANT_BITS+1 cycles regardless of dp_norm_done.
- pack, 1 cycle: go to result.
- result:
  - res_valid=1, held stable with op unchanged until res_ready=1.
  - On res_ready=1, go to idle; res_valid low next cycle.
  - No new command is accepted in the same cycle: cmd_ready stays 0 until idle.
- stage_en: 1 in every state except idle and result.
- busy: 1 in every state except idle.
- cmd_valid with cmd_ready=0 is ignored; the command is not queued.
- All outputs are registered or decoded from the state register only; no combinational path from inputs to outputs.

Optional Feature:
- Macro: FPU_SEQUENCER_PERF_EN.
- When defined, adds outputs perf_ops (32 bit) and perf_busy (32 bit):
  - perf_ops increments on each res_valid&&res_ready.
  - perf_busy increments every cycle busy=1.
  - Both reset to 0 and wrap modulo 2^32.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package fpu_pkg holds:
  - stage enum typedef with the codes above.
  - cmd encoding constants.
  - functions exp_bits(bitness), mant_bits(bitness), div_cycles(bitness).
  - The datapath shares this package.
- One sub-module is natural: fpu_seq_counter, a loadable down-counter with a zero flag, instanced once and reused for mul, div and the normalize limit.

Test Plan:
- Add, bitness=64, dp_special=0, dp_norm_done rises in the 2nd normalize cycle, res_ready=1:
  - Accept at cycle 0.
  - Stages unpack/align/sum/normalize/normalize/pack on cycles 1-6.
  - res_valid=1 at cycle 7, idle at cycle 8.
- Div, bitness=64, dp_norm_done=1 throughout:
  - Stage div for exactly 55 cycles (2-56), normalize 57, pack 58, res_valid at 59.
- Mul with dp_special=1 in unpack: unpack -> pack -> result; mul stage never seen; res_valid at cycle 3.
- res_ready held 0 for 10 cycles in result:
  - res_valid and op stay stable; cmd_valid pulses ignored (cmd_ready=0).
  - Releasing res_ready returns to idle next cycle.
- dp_norm_done stuck 0 on sub: normalize lasts exactly 54 cycles, then pack.
- reset_n pulsed low mid-div (cycle 20): outputs return to reset values immediately; a new add command after release completes normally.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU sequencer and datapath: stage codes,
// command encodings and format-size helpers.
package fpu_pkg;

    typedef enum logic [3:0] {
        ST_UNPACK = 4'b0000,
        ST_PACK   = 4'b0001,
        ST_ALIGN  = 4'b0010,
        ST_NORM   = 4'b0011,
        ST_SUM    = 4'b0100,
        ST_SUB    = 4'b0101,
        ST_MUL    = 4'b0110,
        ST_DIV    = 4'b1000,
        ST_RESULT = 4'b1110,
        ST_IDLE   = 4'b1111
    } stage_e;

    localparam logic [1:0] CMD_ADD = 2'b00;
    localparam logic [1:0] CMD_SUB = 2'b01;
    localparam logic [1:0] CMD_MUL = 2'b10;
    localparam logic [1:0] CMD_DIV = 2'b11;

    // Wide enough for the largest div_cycles (239) and any sane mul_cycles.
    localparam int CNT_W = 16;

    // Formats are keyed by word width; width-minus-one is accepted too.
    function automatic int exp_bits(input int bitness);
        case (bitness)
            15, 16:   return 5;
            31, 32:   return 8;
            127, 128: return 15;
            255, 256: return 19;
            default:  return 11;
        endcase
    endfunction

    function automatic int mant_bits(input int bitness);
        case (bitness)
            15, 16:   return 11;
            31, 32:   return 24;
            127, 128: return 113;
            255, 256: return 237;
            default:  return 53;
        endcase
    endfunction

    function automatic int div_cycles(input int bitness);
        return mant_bits(bitness) + 2;
    endfunction

endpackage

// File: rtl/fpu_seq_counter.sv
// Loadable down-counter with a zero flag; shared by the mul, div and
// normalize-limit phases of the sequencer.
module fpu_seq_counter
    import fpu_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state uses non-blocking assignments and an async clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/fpu_sequencer.sv
// Multi-cycle control FSM stepping the FPU datapath through its stages.
// Optional perf counters are enabled with FPU_SEQUENCER_PERF_EN.
module fpu_sequencer
    import fpu_pkg::*;
#(
    parameter int bitness    = 64,
    parameter int mul_cycles = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic       dp_special,
    input  logic       dp_norm_done,
    output logic [3:0] stage,
    output logic       stage_en,
    output logic [1:0] op,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       busy
`ifdef FPU_SEQUENCER_PERF_EN
    ,
    output logic [31:0] perf_ops,
    output logic [31:0] perf_busy
`endif
);

    // Counter loads are "cycles - 1" because the zero cycle is the last one spent.
    localparam logic [CNT_W-1:0] MUL_LOAD  = CNT_W'((mul_cycles > 1) ? mul_cycles - 1 : 0);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(div_cycles(bitness) - 1);
    localparam logic [CNT_W-1:0] NORM_LOAD = CNT_W'(mant_bits(bitness));

    stage_e           state;
    logic [1:0]       op_q;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;

    fpu_seq_counter #(.WIDTH(CNT_W)) u_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // The counter is armed on the cycle before each timed phase begins.
    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        case (state)
            ST_UNPACK: begin
                cnt_load = 1'b1;
                cnt_val  = (op_q == CMD_DIV) ? DIV_LOAD : MUL_LOAD;
            end
            ST_SUM, ST_SUB: begin
                cnt_load = 1'b1;
                cnt_val  = NORM_LOAD;
            end
            ST_MUL, ST_DIV: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_val  = NORM_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_NORM: cnt_dec = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            op_q  <= CMD_ADD;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= cmd;
                        state <= ST_UNPACK;
                    end
                end
                ST_UNPACK: begin
                    if (dp_special) begin
                        state <= ST_PACK;
                    end else begin
                        case (op_q)
                            CMD_MUL: state <= ST_MUL;
                            CMD_DIV: state <= ST_DIV;
                            default: state <= ST_ALIGN;
                        endcase
                    end
                end
                ST_ALIGN:      state <= (op_q == CMD_SUB) ? ST_SUB : ST_SUM;
                ST_SUM, ST_SUB: state <= ST_NORM;
                ST_MUL, ST_DIV: if (cnt_zero) state <= ST_NORM;
                ST_NORM:       if (dp_norm_done || cnt_zero) state <= ST_PACK;
                ST_PACK:       state <= ST_RESULT;
                ST_RESULT:     if (res_ready) state <= ST_IDLE;
                default:       state <= ST_IDLE;
            endcase
        end
    end

    assign stage     = state;
    assign op        = op_q;
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign res_valid = (state == ST_RESULT);
    assign stage_en  = (state != ST_IDLE) && (state != ST_RESULT);

`ifdef FPU_SEQUENCER_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_ops  <= '0;
            perf_busy <= '0;
        end else begin
            if (res_valid && res_ready) perf_ops <= perf_ops + 32'd1;
            if (busy) perf_busy <= perf_busy + 32'd1;
        end
    end
`endif

endmodule
